// File: rtl/multiplicador_if.sv
// Handshake bus between the datapath controller and the sequential multiplier.
//   master (controller): drives St, Multiplicador, Multiplicando;
//                        observes Idle, Done, Produto
//   slave  (multiplier): the mirror image
interface multiplicador_if #(
  parameter int N = 16
);
  logic           St;
  logic [N-1:0]   Multiplicador;
  logic [N-1:0]   Multiplicando;
  logic           Idle;
  logic           Done;
  logic [2*N-1:0] Produto;

  modport master (output St, Multiplicador, Multiplicando,
                  input  Idle, Done, Produto);
  modport slave  (input  St, Multiplicador, Multiplicando,
                  output Idle, Done, Produto);
endinterface

// File: rtl/multiplicador.sv
// Sequential unsigned shift-and-add multiplier, N x N -> 2N bits.
// One partial-product step per clock; N steps per multiply.
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   bus.St            start request, accepted only while Idle=1
//   bus.Multiplicador multiplier, captured on the accepting edge
//   bus.Multiplicando multiplicand, captured on the accepting edge
//   bus.Idle          1 = ready to accept St
//   bus.Done          one-cycle pulse, Produto valid
//   bus.Produto       registered product, held until the next result
module multiplicador #(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst,
  multiplicador_if.slave   bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [N-1:0]   r_mc;
  logic [N:0]     r_acc;    // carry + upper half
  logic [N-1:0]   r_low;    // multiplier, consumed LSB first
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_prod;

  logic [N:0]     w_sum;
  logic [2*N:0]   w_shift;
  logic           w_last;

  // Add MC into the upper half when the current multiplier bit is set,
  // then shift the whole {carry,high,low} chain right by one.
  assign w_sum   = r_acc + (r_low[0] ? {1'b0, r_mc} : '0);
  assign w_shift = {w_sum, r_low} >> 1;
  assign w_last  = (r_cnt == CW'(N - 1));

  always_comb begin
    w_next   = r_state;
    bus.Idle = 1'b0;
    bus.Done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        bus.Idle = 1'b1;
        if (bus.St) w_next = S_CALC;
      end
      S_CALC: if (w_last) w_next = S_DONE;
      S_DONE: begin
        bus.Done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mc   <= '0;
      r_acc  <= '0;
      r_low  <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.St) begin
          r_mc  <= bus.Multiplicando;
          r_low <= bus.Multiplicador;
          r_acc <= '0;
          r_cnt <= '0;
        end
        S_CALC: begin
          r_acc <= w_shift[2*N:N];
          r_low <= w_shift[N-1:0];
          r_cnt <= r_cnt + 1'b1;
          // Product is published only once, on the step that finishes it.
          if (w_last) r_prod <= w_shift[2*N-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.Produto = r_prod;
endmodule

// File: tb/tb_multiplicador.sv
module tb_multiplicador;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [2*N-1:0] prev_prod;

  always #5 clk = ~clk;

  multiplicador_if #(.N(N)) bus ();
  multiplicador #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain unsigned arithmetic on the operands captured at start.
  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[2*N-1:0];
  endfunction

  // Start a multiply and follow it to Done. If hold_st, St stays high and the
  // operands are scrambled every CALC cycle; the result must still use the
  // values present on the accepting edge.
  task automatic run_mul(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold_st);
    int cyc = 0;
    logic [2*N-1:0] exp;
    bit held_ok = 1;
    exp = ref_mul(a, b);
    chk("idle_before_start", bus.Idle, 1);
    bus.St = 1'b1; bus.Multiplicador = a; bus.Multiplicando = b;
    @(posedge clk); #1;
    if (!hold_st) begin
      bus.St = 1'b0;
      bus.Multiplicador = N'($urandom); bus.Multiplicando = N'($urandom);
    end
    chk("idle_low_in_calc", bus.Idle, 0);
    while (!bus.Done && cyc < 40) begin
      if (bus.Produto !== prev_prod) held_ok = 0;
      if (hold_st) begin
        bus.Multiplicador = N'($urandom); bus.Multiplicando = N'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.St = 1'b0;
    chk("produto_held_in_calc", held_ok, 1);
    chk("done_latency", cyc, 16);
    chk("produto", bus.Produto, exp);
    chk("idle_low_in_done", bus.Idle, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.Done, 0);
    chk("idle_after_done", bus.Idle, 1);
    chk("produto_held_idle", bus.Produto, exp);
    prev_prod = exp;
  endtask

  initial begin
    bit no_done;
    bus.St = 1'b0; bus.Multiplicador = '0; bus.Multiplicando = '0;

    // Reset state
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_idle", bus.Idle, 1);
    chk("rst_done", bus.Done, 0);
    chk("rst_produto", bus.Produto, 0);
    prev_prod = '0;

    // Directed cases
    run_mul(16'd5000, 16'd6000, 0);
    run_mul(16'd13, 16'd10, 0);
    run_mul(16'hFFFF, 16'hFFFF, 0);
    run_mul(16'd3, 16'd15, 0);
    run_mul(16'd1, 16'd1, 0);
    run_mul(16'd0, 16'hABCD, 0);
    run_mul(16'h8001, 16'd0, 0);

    // St held high with operands changing during CALC
    run_mul(16'd1234, 16'd4321, 1);

    // Randomized
    for (int i = 0; i < 25; i++)
      run_mul(N'($urandom), N'($urandom), 0);

    // Back-to-back start immediately after Idle returns
    run_mul(16'd7, 16'd9, 0);
    run_mul(16'hFFFF, 16'd2, 0);

    // Reset mid-CALC aborts with no Done pulse
    bus.St = 1'b1; bus.Multiplicador = 16'd300; bus.Multiplicando = 16'd400;
    @(posedge clk); #1;
    bus.St = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("calc_before_abort", bus.Idle, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_idle", bus.Idle, 1);
    chk("abort_produto", bus.Produto, 0);
    no_done = 1;
    repeat (20) begin
      if (bus.Done !== 1'b0 || bus.Idle !== 1'b1) no_done = 0;
      @(posedge clk); #1;
    end
    chk("abort_no_done", no_done, 1);
    prev_prod = '0;

    // rst and St on the same edge: start must not be accepted
    rst = 1'b1; bus.St = 1'b1; bus.Multiplicador = 16'd2; bus.Multiplicando = 16'd3;
    @(posedge clk); #1;
    rst = 1'b0; bus.St = 1'b0;
    chk("rst_st_idle", bus.Idle, 1);
    @(posedge clk); #1;
    chk("rst_st_still_idle", bus.Idle, 1);
    chk("rst_st_produto", bus.Produto, 0);

    run_mul(16'd65535, 16'd1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
